mem_stage_dcache: RTL

Memory-stage data cache that sits directly upstream of the MEM/WB pipeline register. It serves loads and stores issued from the memory stage, returns load data on `DMRd`, and raises `mem_stall` whenever the pipeline must hold. The cache is direct-mapped and write-through with no write-allocate. It refills 4-word lines from main memory over a simple req/ready handshake.

---
 rtl/mem_stage_dcache.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module mem_stage_dcache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [31:0]           ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] DMRd,
    output logic                  mem_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t                state;
    logic [1:0]            beat;
    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][4];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    logic             hit;
    logic             is_load;
    logic             is_store;
    logic             load_hit;

    assign off      = ALUResultM[3:2];
    assign idx      = ALUResultM[4+IDX_W-1:4];
    assign tag      = ALUResultM[31:4+IDX_W];
    assign hit      = valid[idx] && (tag_mem[idx] == tag);
    assign is_store = MemWriteM;
    assign is_load  = MemReadM && !MemWriteM;
    assign load_hit = (state == IDLE) && is_load && hit;

    always_comb begin
        mem_stall = 1'b0;
        DMRd      = '0;
        case (state)
            IDLE: begin
                mem_stall = is_store || (is_load && !hit);
                if (load_hit) begin
                    DMRd = data_mem[idx][off];
                end
            end
            REFILL, WRITE: mem_stall = 1'b1;
            default: ;
        endcase
    end

    // Memory-side outputs are registered: they are loaded on entry to REFILL/WRITE
    // and advanced per accepted beat, so reset drops mem_req immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_store) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ALUResultM & ~32'h3;
                        mem_wdata <= WriteDataM;
                    end else if (is_load && !hit) begin
                        state    <= REFILL;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ALUResultM & ~32'hF;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            valid[idx] <= 1'b1;
                            state      <= IDLE;
                            mem_req    <= 1'b0;
                            mem_addr   <= '0;
                        end else begin
                            mem_addr[3:2] <= beat + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ready) begin
            data_mem[idx][beat] <= mem_rdata;
            if (beat == 2'd3) begin
                tag_mem[idx] <= tag;
            end
        end else if (state == WRITE && mem_ready && hit) begin
            data_mem[idx][off] <= WriteDataM;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (load_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (state == IDLE && is_load && !hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
